// File: rtl/sdc_drive_mux.sv
// sdc_drive_mux: round-robin arbiter that lets NUM_DRIVES drive channels share
// one SD card engine. Each drive owns a slot of 2**SLOT_SHIFT sectors on the
// card. The owning drive's slot index is placed above its sector address to form
// the absolute card sector.
// Optional feature: define SDC_BOUNDS_CHECK_EN to reject requests whose address
// does not fit in the slot (drv_err pulse). When it is not defined, the upper
// address bits are dropped and the address wraps within the slot.
module sdc_drive_mux #(
  parameter int NUM_DRIVES = 4,
  parameter int LBA_W      = 24,
  parameter int SLOT_SHIFT = 21
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_DRIVES-1:0]       req_rd,
  input  logic [NUM_DRIVES-1:0]       req_wr,
  input  logic [NUM_DRIVES*LBA_W-1:0] req_lba,
  output logic [NUM_DRIVES-1:0]       drv_busy,
  output logic [NUM_DRIVES-1:0]       drv_done,
  output logic [NUM_DRIVES-1:0]       drv_err,
  output logic                        sdc_rstart,
  output logic                        sdc_wstart,
  output logic [31:0]                 sdc_sector,
  input  logic                        sdc_busy,
  input  logic                        sdc_done,
  output logic [2:0]                  grant
);

  localparam logic [NUM_DRIVES-1:0] ONE_HOT0  = NUM_DRIVES'(1);
  localparam logic [31:0]           SLOT_MASK = (32'd1 << SLOT_SHIFT) - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [2:0]              last_grant;
  logic                    op_rd;
  logic                    win_found;
  logic [2:0]              win_idx;
  logic                    win_rd;
  logic [LBA_W-1:0]        win_lba;
  logic [NUM_DRIVES-1:0]   req_any;
  logic [NUM_DRIVES-1:0]   grant_hot;

  // Absolute card sector: slot index above the in-slot sector bits.
  function automatic logic [31:0] slot_sector(input logic [2:0] drive,
                                              input logic [LBA_W-1:0] lba);
    logic [31:0] lba32;
    lba32 = 32'(lba);
    return (32'(drive) << SLOT_SHIFT) | (lba32 & SLOT_MASK);
  endfunction

  // True when any address bit at or above SLOT_SHIFT is set.
  function automatic logic lba_outside_slot(input logic [LBA_W-1:0] lba);
    logic [31:0] lba32;
    lba32 = 32'(lba);
    return (lba32 & ~SLOT_MASK) != 32'd0;
  endfunction

  assign req_any   = req_rd | req_wr;
  assign grant_hot = ONE_HOT0 << grant;

  // Round-robin search starting one past the last granted drive.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int k = 1; k <= NUM_DRIVES; k++) begin
      if (!win_found && req_any[(int'(last_grant) + k) % NUM_DRIVES]) begin
        win_found = 1'b1;
        win_idx   = 3'((int'(last_grant) + k) % NUM_DRIVES);
      end
    end
  end

  // Read wins over write when a drive asserts both.
  assign win_rd  = req_rd[win_idx];
  assign win_lba = req_lba[int'(win_idx)*LBA_W +: LBA_W];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a done seen before busy counts as busy-then-done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (win_found) begin
`ifdef SDC_BOUNDS_CHECK_EN
          if (!lba_outside_slot(win_lba)) state_nxt = S_ISSUE;
`else
          state_nxt = S_ISSUE;
`endif
        end
      end
      S_ISSUE, S_WAIT_BUSY: begin
        if (sdc_done)      state_nxt = S_FINISH;
        else if (sdc_busy) state_nxt = S_WAIT_DONE;
        else               state_nxt = S_WAIT_BUSY;
      end
      S_WAIT_DONE: if (sdc_done) state_nxt = S_FINISH;
      S_FINISH:    state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Grant, operation type and card sector are captured once, at arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 3'd0;
      last_grant <= 3'(NUM_DRIVES - 1);
      op_rd      <= 1'b0;
      sdc_sector <= 32'd0;
    end else if (state == S_IDLE && win_found) begin
      grant      <= win_idx;
      last_grant <= win_idx;
      op_rd      <= win_rd;
`ifdef SDC_BOUNDS_CHECK_EN
      if (!lba_outside_slot(win_lba)) sdc_sector <= slot_sector(win_idx, win_lba);
`else
      sdc_sector <= slot_sector(win_idx, win_lba);
`endif
    end
  end

`ifdef SDC_BOUNDS_CHECK_EN
  logic [NUM_DRIVES-1:0] err_pulse;

  // One-cycle rejection pulse for an out-of-slot request.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= '0;
    end else begin
      err_pulse <= '0;
      if (state == S_IDLE && win_found && lba_outside_slot(win_lba))
        err_pulse <= ONE_HOT0 << win_idx;
    end
  end

  assign drv_err = err_pulse;
`else
  assign drv_err = '0;
`endif

  // Output decode from the current state.
  always_comb begin
    drv_busy   = '0;
    drv_done   = '0;
    sdc_rstart = 1'b0;
    sdc_wstart = 1'b0;
    case (state)
      S_ISSUE, S_WAIT_BUSY: begin
        drv_busy   = grant_hot;
        sdc_rstart = op_rd;
        sdc_wstart = !op_rd;
      end
      S_WAIT_DONE: drv_busy = grant_hot;
      S_FINISH:    drv_done = grant_hot;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sdc_drive_mux.sv
// Randomized self-checking bench for sdc_drive_mux. The bench plays the SD
// engine and predicts every transaction from a transaction-level model:
// round-robin winner, read priority, slot address and fixed latencies.
// Define SDC_BOUNDS_CHECK_EN together with the RTL to check the bounds option.
module tb_sdc_drive_mux;
  localparam int N  = 4;
  localparam int LW = 24;
  localparam int SS = 21;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_rd, req_wr;
  logic [N*LW-1:0] req_lba;
  logic [N-1:0]    drv_busy, drv_done, drv_err;
  logic            sdc_rstart, sdc_wstart;
  logic [31:0]     sdc_sector;
  logic            sdc_busy, sdc_done;
  logic [2:0]      grant;

  int n_checks = 0;
  int n_errors = 0;
  int last_g;
  bit need_gap;

  sdc_drive_mux #(.NUM_DRIVES(N), .LBA_W(LW), .SLOT_SHIFT(SS)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
    .drv_busy(drv_busy), .drv_done(drv_done), .drv_err(drv_err),
    .sdc_rstart(sdc_rstart), .sdc_wstart(sdc_wstart), .sdc_sector(sdc_sector),
    .sdc_busy(sdc_busy), .sdc_done(sdc_done), .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"},   32'(drv_busy),   32'd0);
    check({tag, "_done"},   32'(drv_done),   32'd0);
    check({tag, "_err"},    32'(drv_err),    32'd0);
    check({tag, "_rstart"}, 32'(sdc_rstart), 32'd0);
    check({tag, "_wstart"}, 32'(sdc_wstart), 32'd0);
  endtask

  // Model: first requesting drive after the previous owner, wrapping around.
  function automatic int rr_winner(input logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(last_g + k) % N]) return (last_g + k) % N;
    return 0;
  endfunction

  function automatic logic [N*LW-1:0] rand_lbas();
    logic [N*LW-1:0] l;
    logic [31:0]     v;
    for (int i = 0; i < N; i++) begin
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v = v % (32'd1 << SS);
      l[i*LW +: LW] = v[LW-1:0];
    end
    return l;
  endfunction

  // One complete transaction; db = cycles before the engine shows busy,
  // dd = cycles of busy before done, same = done together with busy.
  task automatic run_txn(input logic [N-1:0] rd, input logic [N-1:0] wr,
                         input logic [N*LW-1:0] lbas, input int db, input int dd,
                         input bit same, output int w);
    logic [LW-1:0] my_lba;
    logic [31:0]   exp_sec;
    logic [31:0]   hot;
    bit            rdop, bad;
    req_rd = rd; req_wr = wr; req_lba = lbas;
    if (need_gap) begin
      tick();
      check_quiet("gap");
    end
    w       = rr_winner(rd | wr);
    my_lba  = lbas[w*LW +: LW];
    rdop    = rd[w];
    hot     = 32'd1 << w;
    exp_sec = 32'(w) * (32'd1 << SS) + (32'(my_lba) % (32'd1 << SS));
    last_g  = w;
`ifdef SDC_BOUNDS_CHECK_EN
    bad = (32'(my_lba) >= (32'd1 << SS));
`else
    bad = 1'b0;
`endif
    tick();
    if (bad) begin
      check("err_pulse",  32'(drv_err),    hot);
      check("err_rstart", 32'(sdc_rstart), 32'd0);
      check("err_wstart", 32'(sdc_wstart), 32'd0);
      check("err_busy",   32'(drv_busy),   32'd0);
      req_rd = '0; req_wr = '0;
      tick();
      check_quiet("err_after");
      need_gap = 1'b0;
      return;
    end
    check("grant",  32'(grant),      32'(w));
    check("sector", sdc_sector,      exp_sec);
    check("rstart", 32'(sdc_rstart), 32'(rdop));
    check("wstart", 32'(sdc_wstart), 32'(!rdop));
    check("busy",   32'(drv_busy),   hot);
    check("err0",   32'(drv_err),    32'd0);
    // Requests and addresses may change freely once granted.
    req_rd = N'($urandom); req_wr = N'($urandom); req_lba = rand_lbas();
    for (int i = 0; i < db; i++) begin
      tick();
      check("hold_rstart", 32'(sdc_rstart), 32'(rdop));
      check("hold_wstart", 32'(sdc_wstart), 32'(!rdop));
      check("hold_busy",   32'(drv_busy),   hot);
      check("hold_sector", sdc_sector,      exp_sec);
    end
    sdc_busy = 1'b1;
    sdc_done = same;
    tick();
    if (same) begin
      sdc_busy = 1'b0; sdc_done = 1'b0;
      check("fast_done",   32'(drv_done), hot);
      check("fast_busy",   32'(drv_busy), 32'd0);
      check("fast_starts", 32'({sdc_rstart, sdc_wstart}), 32'd0);
    end else begin
      sdc_done = 1'b0;
      check("drop_starts", 32'({sdc_rstart, sdc_wstart}), 32'd0);
      check("wd_busy",     32'(drv_busy), hot);
      check("wd_done",     32'(drv_done), 32'd0);
      for (int i = 0; i < dd; i++) begin
        tick();
        check("wait_busy", 32'(drv_busy), hot);
        check("wait_done", 32'(drv_done), 32'd0);
      end
      sdc_done = 1'b1; sdc_busy = 1'b0;
      tick();
      sdc_done = 1'b0;
      check("done_pulse",  32'(drv_done), hot);
      check("done_busy",   32'(drv_busy), 32'd0);
      check("done_starts", 32'({sdc_rstart, sdc_wstart}), 32'd0);
    end
    check("done_err", 32'(drv_err), 32'd0);
    need_gap = 1'b1;
  endtask

  initial begin
    int              w;
    int              exp_order [4] = '{0, 1, 0, 1};
    logic [N*LW-1:0] l;
    reset = 1'b1; req_rd = '0; req_wr = '0; req_lba = '0;
    sdc_busy = 1'b0; sdc_done = 1'b0;
    repeat (3) tick();
    check_quiet("rst");
    check("rst_sector", sdc_sector,  32'd0);
    check("rst_grant",  32'(grant),  32'd0);
    reset = 1'b0; last_g = N - 1; need_gap = 1'b0;

    // Drive 2 read at sector 0x10, engine busy three cycles after start.
    l = '0; l[2*LW +: LW] = 24'h000010;
    run_txn(4'b0100, 4'b0000, l, 3, 2, 1'b0, w);
    check("d2_sector_abs", sdc_sector,     32'h0040_0010);
    check("d2_done_bit",   32'(drv_done),  32'h4);

    // Drives 0 and 1 contend repeatedly: strict alternation.
    for (int i = 0; i < 4; i++) begin
      run_txn(4'b0011, 4'b0000, rand_lbas(), $urandom_range(0, 2), $urandom_range(0, 2), 1'b0, w);
      check("alt_order", 32'(grant), 32'(exp_order[i]));
    end

    // Read and write together on drive 1: read only.
    l = '0; l[1*LW +: LW] = 24'h000123;
    run_txn(4'b0010, 4'b0010, l, 1, 1, 1'b0, w);

    // Drive 3 address at the slot boundary.
    l = '0; l[3*LW +: LW] = 24'h200000;
    run_txn(4'b1000, 4'b0000, l, 0, 0, 1'b0, w);
`ifndef SDC_BOUNDS_CHECK_EN
    check("wrap_sector", sdc_sector, 32'h0060_0000);
`endif

    // Done arriving together with busy.
    l = '0; l[0*LW +: LW] = 24'h0ABCDE;
    run_txn(4'b0000, 4'b0001, l, 2, 0, 1'b1, w);
    tick();
    check("fast_idle_done", 32'(drv_done), 32'd0);
    req_rd = '0; req_wr = '0;
    need_gap = 1'b0;

    // Reset while waiting for done abandons the operation silently.
    req_wr = 4'b0010; req_lba = '0;
    tick();
    sdc_busy = 1'b1;
    tick();
    check("rst_mid_busy", 32'(drv_busy), 32'h2);
    reset = 1'b1; sdc_busy = 1'b0; sdc_done = 1'b1; req_wr = '0;
    tick();
    check_quiet("rst_mid");
    check("rst_mid_sector", sdc_sector, 32'd0);
    check("rst_mid_grant",  32'(grant), 32'd0);
    reset = 1'b0; sdc_done = 1'b0;
    tick();
    check_quiet("rst_after");
    last_g = N - 1; need_gap = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic [N-1:0] rd, wr;
      rd = N'($urandom); wr = N'($urandom);
      if ((rd | wr) == '0) rd[$urandom_range(0, N-1)] = 1'b1;
      run_txn(rd, wr, rand_lbas(), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0), w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
